// File: rtl/rename_regfile.sv
// Architectural register file with per-register ROB rename tags and two dispatch read ports.
// Define RF_COMMIT_BYPASS_EN to forward same-cycle commit data to reads whose tag matches the commit.
module rename_regfile #(
    parameter int NICK_W  = 5,
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              iROB_nick_en,
    input  logic [NICK_W-1:0] iROB_nick,
    input  logic [4:0]        iROB_nick_regnm,
    input  logic              iCOM_en,
    input  logic [4:0]        iCOM_regnm,
    input  logic [DATA_W-1:0] iCOM_dt,
    input  logic [NICK_W-1:0] iCOM_nick,
    input  logic [4:0]        iRS1_regnm,
    input  logic [4:0]        iRS2_regnm,
    output logic [DATA_W-1:0] oRS1_dt,
    output logic [DATA_W-1:0] oRS2_dt,
    output logic [NICK_W-1:0] oRS1_nick,
    output logic [NICK_W-1:0] oRS2_nick,
    output logic [5:0]        oBusy_cnt
);

    logic [DATA_W-1:0] dt_q  [REG_NUM];
    logic [DATA_W-1:0] dt_d  [REG_NUM];
    logic [NICK_W-1:0] tag_q [REG_NUM];
    logic [NICK_W-1:0] tag_d [REG_NUM];
    logic [5:0]        busy_cnt_q;
    logic [5:0]        busy_cnt_d;

    logic              alloc_valid;
    logic              commit_valid;
    logic [4:0]        rs_regnm [2];
    logic [DATA_W-1:0] rs_dt    [2];
    logic [NICK_W-1:0] rs_nick  [2];

    assign alloc_valid  = rdy && !iclr && iROB_nick_en && (iROB_nick_regnm != 5'd0);
    assign commit_valid = rdy && iCOM_en && (iCOM_regnm != 5'd0);

    // Commit clears the tag first so a same-cycle allocation overrides it; flush wins over both.
    always_comb begin
        dt_d  = dt_q;
        tag_d = tag_q;
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                dt_d[r]  = '0;
                tag_d[r] = '0;
            end
        end else begin
            if (commit_valid) begin
                dt_d[iCOM_regnm] = iCOM_dt;
                if (tag_q[iCOM_regnm] == iCOM_nick)
                    tag_d[iCOM_regnm] = '0;
            end
            if (alloc_valid)
                tag_d[iROB_nick_regnm] = iROB_nick;
            if (rdy && iclr) begin
                for (int r = 0; r < REG_NUM; r++)
                    tag_d[r] = '0;
            end
        end
        dt_d[0]  = '0;
        tag_d[0] = '0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            if (tag_d[r] != '0)
                busy_cnt_d = busy_cnt_d + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        dt_q       <= dt_d;
        tag_q      <= tag_d;
        busy_cnt_q <= busy_cnt_d;
    end

    assign rs_regnm[0] = iRS1_regnm;
    assign rs_regnm[1] = iRS2_regnm;

    // A not-ready operand reports its producing nick; with the bypass a matching commit makes it ready now.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rs_dt[p]   = '0;
            rs_nick[p] = '0;
            if (!rst && rs_regnm[p] != 5'd0) begin
                if (tag_q[rs_regnm[p]] == '0) begin
                    rs_dt[p] = dt_q[rs_regnm[p]];
`ifdef RF_COMMIT_BYPASS_EN
                end else if (iCOM_en && iCOM_regnm == rs_regnm[p] &&
                             iCOM_nick == tag_q[rs_regnm[p]]) begin
                    rs_dt[p] = iCOM_dt;
`endif
                end else begin
                    rs_dt[p]   = dt_q[rs_regnm[p]];
                    rs_nick[p] = tag_q[rs_regnm[p]];
                end
            end
        end
    end

    assign oRS1_dt   = rs_dt[0];
    assign oRS2_dt   = rs_dt[1];
    assign oRS1_nick = rs_nick[0];
    assign oRS2_nick = rs_nick[1];
    assign oBusy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios followed by random traffic
// checked against a register/tag reference model.
module tb_rename_regfile;

    localparam int NICK_W  = 5;
    localparam int DATA_W  = 32;
    localparam int REG_NUM = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              iclr;
    logic              iROB_nick_en;
    logic [NICK_W-1:0] iROB_nick;
    logic [4:0]        iROB_nick_regnm;
    logic              iCOM_en;
    logic [4:0]        iCOM_regnm;
    logic [DATA_W-1:0] iCOM_dt;
    logic [NICK_W-1:0] iCOM_nick;
    logic [4:0]        iRS1_regnm;
    logic [4:0]        iRS2_regnm;
    logic [DATA_W-1:0] oRS1_dt;
    logic [DATA_W-1:0] oRS2_dt;
    logic [NICK_W-1:0] oRS1_nick;
    logic [NICK_W-1:0] oRS2_nick;
    logic [5:0]        oBusy_cnt;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] m_dt  [REG_NUM];
    logic [NICK_W-1:0] m_tag [REG_NUM];
    logic [5:0]        m_busy;

    rename_regfile #(.NICK_W(NICK_W), .DATA_W(DATA_W), .REG_NUM(REG_NUM)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iclr(iclr),
        .iROB_nick_en(iROB_nick_en), .iROB_nick(iROB_nick), .iROB_nick_regnm(iROB_nick_regnm),
        .iCOM_en(iCOM_en), .iCOM_regnm(iCOM_regnm), .iCOM_dt(iCOM_dt), .iCOM_nick(iCOM_nick),
        .iRS1_regnm(iRS1_regnm), .iRS2_regnm(iRS2_regnm),
        .oRS1_dt(oRS1_dt), .oRS2_dt(oRS2_dt), .oRS1_nick(oRS1_nick), .oRS2_nick(oRS2_nick),
        .oBusy_cnt(oBusy_cnt)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and on a difference counts the error and reports it.
    task automatic checkVal(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Expected read result derived from the operand-readiness rules.
    function automatic void modelRead(input logic [4:0] r, output logic [DATA_W-1:0] d,
                                      output logic [NICK_W-1:0] n);
        d = '0;
        n = '0;
        if (rst || r == 5'd0) return;
        if (m_tag[r] == '0) begin
            d = m_dt[r];
            return;
        end
`ifdef RF_COMMIT_BYPASS_EN
        if (iCOM_en && iCOM_regnm == r && iCOM_nick == m_tag[r]) begin
            d = iCOM_dt;
            return;
        end
`endif
        d = m_dt[r];
        n = m_tag[r];
    endfunction

    // Model state update at a clock edge, applied register by register in priority order.
    task automatic modelEdge();
        logic commit_hit;
        logic alloc_hit;
        m_busy = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            commit_hit = rdy && iCOM_en && iCOM_regnm == 5'(r) && r != 0;
            alloc_hit  = rdy && iROB_nick_en && iROB_nick_regnm == 5'(r) && r != 0;
            if (rst) begin
                m_dt[r]  = '0;
                m_tag[r] = '0;
            end else begin
                if (commit_hit) m_dt[r] = iCOM_dt;
                if (rdy && iclr)                          m_tag[r] = '0;
                else if (alloc_hit)                       m_tag[r] = iROB_nick;
                else if (commit_hit && m_tag[r] == iCOM_nick) m_tag[r] = '0;
            end
            if (m_tag[r] != '0) m_busy = m_busy + 6'd1;
        end
    endtask

    task automatic applyStimulus(input logic s_rst, input logic s_rdy, input logic s_clr,
                                 input logic a_en, input logic [4:0] a_nick, input logic [4:0] a_reg,
                                 input logic c_en, input logic [4:0] c_reg, input logic [31:0] c_dt,
                                 input logic [4:0] c_nick, input logic [4:0] r1, input logic [4:0] r2);
        rst = s_rst; rdy = s_rdy; iclr = s_clr;
        iROB_nick_en = a_en; iROB_nick = a_nick; iROB_nick_regnm = a_reg;
        iCOM_en = c_en; iCOM_regnm = c_reg; iCOM_dt = c_dt; iCOM_nick = c_nick;
        iRS1_regnm = r1; iRS2_regnm = r2;
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, r1, r2);
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    // Compare both read ports and the busy count with the model.
    task automatic checkOutput(input string name);
        logic [DATA_W-1:0] ed;
        logic [NICK_W-1:0] en;
        modelRead(iRS1_regnm, ed, en);
        checkVal({name, ".rs1_dt"}, oRS1_dt, ed);
        checkVal({name, ".rs1_nick"}, 32'(oRS1_nick), 32'(en));
        modelRead(iRS2_regnm, ed, en);
        checkVal({name, ".rs2_dt"}, oRS2_dt, ed);
        checkVal({name, ".rs2_nick"}, 32'(oRS2_nick), 32'(en));
        checkVal({name, ".busy"}, 32'(oBusy_cnt), 32'(m_busy));
    endtask

    initial begin
        logic [4:0] cr;
        @(negedge clk);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 5, 0);
        step();
        step();
        checkVal("reset.x5_dt", oRS1_dt, 32'h0);
        checkVal("reset.x5_nick", 32'(oRS1_nick), 32'h0);
        checkVal("reset.x0_dt", oRS2_dt, 32'h0);
        checkVal("reset.busy", 32'(oBusy_cnt), 32'h0);

        $display("[TB] allocate then commit");
        applyStimulus(0, 1, 0, 1, 3, 5, 0, 0, 32'h0, 0, 5, 0);
        checkVal("alloc.same_cycle_nick", 32'(oRS1_nick), 32'h0);
        step();
        idle(5, 0);
        checkVal("alloc.nick", 32'(oRS1_nick), 32'd3);
        checkVal("alloc.busy", 32'(oBusy_cnt), 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 3, 5, 0);
`ifdef RF_COMMIT_BYPASS_EN
        checkVal("commit.bypass_dt", oRS1_dt, 32'hDEADBEEF);
        checkVal("commit.bypass_nick", 32'(oRS1_nick), 32'h0);
`else
        checkVal("commit.nobypass_dt", oRS1_dt, 32'h0);
        checkVal("commit.nobypass_nick", 32'(oRS1_nick), 32'd3);
`endif
        step();
        idle(5, 0);
        checkVal("commit.state_dt", oRS1_dt, 32'hDEADBEEF);
        checkVal("commit.state_nick", 32'(oRS1_nick), 32'h0);
        checkVal("commit.busy", 32'(oBusy_cnt), 32'h0);

        $display("[TB] stale commit");
        applyStimulus(0, 1, 0, 1, 3, 5, 0, 0, 32'h0, 0, 5, 0);
        step();
        applyStimulus(0, 1, 0, 1, 7, 5, 0, 0, 32'h0, 0, 5, 0);
        step();
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 32'h11, 3, 5, 0);
        checkOutput("stale.during");
        step();
        idle(5, 0);
        checkVal("stale.dt", oRS1_dt, 32'h11);
        checkVal("stale.nick", 32'(oRS1_nick), 32'd7);

        $display("[TB] same-cycle allocate and commit");
        applyStimulus(0, 1, 0, 1, 4, 6, 0, 0, 32'h0, 0, 6, 5);
        step();
        applyStimulus(0, 1, 0, 1, 9, 6, 1, 6, 32'h22, 4, 6, 5);
        step();
        idle(6, 5);
        checkVal("samecyc.nick", 32'(oRS1_nick), 32'd9);
        checkVal("samecyc.dt", oRS1_dt, 32'h22);
        checkVal("samecyc.busy", 32'(oBusy_cnt), 32'd2);

        $display("[TB] flush");
        for (int r = 1; r <= 3; r++) begin
            applyStimulus(0, 1, 0, 1, 5'(r), 5'(r), 0, 0, 32'h0, 0, 1, 2);
            step();
        end
        applyStimulus(0, 1, 1, 1, 12, 4, 1, 1, 32'h33, 1, 1, 4);
        step();
        idle(1, 4);
        checkVal("flush.x1_dt", oRS1_dt, 32'h33);
        checkVal("flush.x1_nick", 32'(oRS1_nick), 32'h0);
        checkVal("flush.x4_nick", 32'(oRS2_nick), 32'h0);
        checkVal("flush.busy", 32'(oBusy_cnt), 32'h0);

        $display("[TB] x0 and rdy");
        applyStimulus(0, 1, 0, 1, 5, 0, 1, 0, 32'hFF, 0, 0, 7);
        step();
        idle(0, 7);
        checkVal("x0.dt", oRS1_dt, 32'h0);
        checkVal("x0.nick", 32'(oRS1_nick), 32'h0);
        applyStimulus(0, 0, 0, 1, 8, 7, 0, 0, 32'h0, 0, 0, 7);
        step();
        idle(0, 7);
        checkVal("rdy_low.nick", 32'(oRS2_nick), 32'h0);
        checkVal("rdy_low.busy", 32'(oBusy_cnt), 32'h0);
        checkOutput("directed.end");

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            cr = 5'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) >= 10),
                          ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 60),
                          5'($urandom_range(1, 31)), 5'($urandom_range(0, 7)),
                          ($urandom_range(0, 99) < 50), cr, $urandom,
                          ($urandom_range(0, 1) == 1) ? m_tag[cr] : 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 1) == 1) ? cr : 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)));
            checkOutput("random");
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
